// File: rtl/vga_fb_fetch_arbiter.sv
// Frame-buffer port sequencer: prefetches the next visible line into a ping-pong
// line buffer each display line and lends spare RAM cycles to a drawing client.
module vga_fb_fetch_arbiter #(
   parameter int WIDTH  = 683,
   parameter int HEIGHT = 768,
   parameter int H_L    = 896,
   parameter int V_L    = 795,
   parameter int PW     = 8,
   parameter int AW     = 20,
   parameter int GUARD  = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [$clog2(H_L)-1:0]    h_count,
   input  logic [$clog2(V_L)-1:0]    v_count,
   input  logic                      wr_valid,
   output logic                      wr_ready,
   input  logic [AW-1:0]             wr_addr,
   input  logic [PW-1:0]             wr_data,
   output logic                      mem_en,
   output logic                      mem_we,
   output logic [AW-1:0]             mem_addr,
   output logic [PW-1:0]             mem_wdata,
   input  logic [PW-1:0]             mem_rdata,
   output logic                      lb_we,
   output logic [$clog2(WIDTH):0]    lb_waddr,
   output logic [PW-1:0]             lb_wdata,
   output logic                      lb_rd_bank,
   output logic                      fetch_busy,
   output logic                      underrun
);

   localparam int HW = $clog2(H_L);
   localparam int VW = $clog2(V_L);
   localparam int CW = $clog2(WIDTH);
   localparam int IW = CW + 1;
   localparam int SW = 16;
   localparam logic [AW-1:0] PIXELS = AW'(WIDTH * HEIGHT);

   typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

   state_t        state_q, state_d, curState;
   logic [AW-1:0] base_q, base_d, curBase;
   logic [IW-1:0] issued_q, issued_d, curIssued;
   logic          lineFetch_q, lineFetch_d, curLineFetch;
   logic          rdBank_q, rdBank_d;
   logic          underrun_q, underrun_d;
   logic          retValid_q, retBank_q;
   logic [CW-1:0] retCol_q;

   logic          startLine, lastCycle, targetVisible, slackOk;
   logic          wrXfer, wrInRange, readIssue;
   logic [VW-1:0] target;
   logic [SW-1:0] cyclesLeft, remaining;

   assign startLine     = (h_count == HW'(0));
   assign lastCycle     = (h_count == HW'(H_L));
   assign target        = (v_count == VW'(V_L)) ? '0 : v_count + VW'(1);
   assign targetVisible = (target < VW'(HEIGHT));

   // The h_count==0 decision takes effect in the same cycle, so the first read issues at h=0.
   always_comb begin
      curState     = state_q;
      curIssued    = issued_q;
      curBase      = base_q;
      curLineFetch = lineFetch_q;
      if (startLine) begin
         curIssued    = '0;
         curLineFetch = targetVisible;
         if (targetVisible) begin
            curState = FETCH;
            curBase  = (target == '0) ? '0 : base_q + AW'(WIDTH);
         end else begin
            curState = DONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         base_q      <= '0;
         issued_q    <= '0;
         lineFetch_q <= 1'b0;
         rdBank_q    <= 1'b0;
         underrun_q  <= 1'b0;
         retValid_q  <= 1'b0;
         retBank_q   <= 1'b0;
         retCol_q    <= '0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         issued_q    <= issued_d;
         lineFetch_q <= lineFetch_d;
         rdBank_q    <= rdBank_d;
         underrun_q  <= underrun_d;
         retValid_q  <= readIssue;
         retBank_q   <= ~rdBank_q;
         retCol_q    <= curIssued[CW-1:0];
      end
   end

   always_comb begin
      state_d     = curState;
      base_d      = curBase;
      issued_d    = curIssued;
      lineFetch_d = curLineFetch;
      rdBank_d    = rdBank_q;
      underrun_d  = underrun_q;
      if (readIssue) begin
         issued_d = curIssued + IW'(1);
         if (curIssued == IW'(WIDTH - 1)) begin
            state_d = DONE;
         end
      end
      if (lastCycle) begin
         if (curState == FETCH) begin
            underrun_d = 1'b1;
            state_d    = DONE;
         end
         if (curLineFetch) begin
            rdBank_d = ~rdBank_q;
         end
      end
   end

   // No read at h==H_L: its return would land in the bank being displayed next line.
   always_comb begin
      cyclesLeft = SW'(H_L) - SW'(h_count);
      remaining  = SW'(WIDTH) - SW'(curIssued);
      slackOk    = (cyclesLeft > remaining + SW'(GUARD));
      wr_ready   = (curState != FETCH) || slackOk;
      wrXfer     = wr_valid && wr_ready;
      wrInRange  = (wr_addr < PIXELS);
      readIssue  = (curState == FETCH) && !lastCycle && !wrXfer;
      mem_we     = wrXfer && wrInRange;
      mem_en     = readIssue || mem_we;
      mem_addr   = mem_we ? wr_addr : curBase + AW'(curIssued);
      mem_wdata  = wr_data;
      lb_we      = retValid_q;
      lb_waddr   = {retBank_q, retCol_q};
      lb_wdata   = mem_rdata;
      lb_rd_bank = rdBank_q;
      underrun   = underrun_q;
      fetch_busy = (curState == FETCH) || retValid_q;
   end

endmodule

// File: tb/tb_vga_fb_fetch_arbiter.sv
// Randomized bench for vga_fb_fetch_arbiter against a line-level reference model
// (line base = target*WIDTH, reads counted per line, slack rule evaluated directly).
module tb_vga_fb_fetch_arbiter;

   localparam int WIDTH  = 683;
   localparam int HEIGHT = 768;
   localparam int H_L    = 896;
   localparam int V_L    = 795;
   localparam int GUARD  = 4;
   localparam int PIXELS = WIDTH * HEIGHT;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  h_count, v_count;
   logic        wr_valid, wr_ready;
   logic [19:0] wr_addr;
   logic [7:0]  wr_data;
   logic        mem_en, mem_we;
   logic [19:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata;
   logic        lb_we;
   logic [10:0] lb_waddr;
   logic [7:0]  lb_wdata;
   logic        lb_rd_bank, fetch_busy, underrun;

   int checks = 0;
   int failures = 0;

   int mRdBank, mUnderrun, mActive, mLineFetch, mPend, mPendCol, mPendBank, mIssued, mBase;
   int obsReads, obsGrants, obsFirstRead;

   vga_fb_fetch_arbiter dut (
      .clk(clk), .rst_n(rst_n), .h_count(h_count), .v_count(v_count),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .lb_we(lb_we), .lb_waddr(lb_waddr), .lb_wdata(lb_wdata),
      .lb_rd_bank(lb_rd_bank), .fetch_busy(fetch_busy), .underrun(underrun)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      mRdBank = 0; mUnderrun = 0; mActive = 0; mLineFetch = 0;
      mPend = 0; mPendCol = 0; mPendBank = 0; mIssued = 0; mBase = 0;
   endtask

   // One clock: drive at posedge+1, compare at posedge+4, advance the model, move to next posedge+1.
   task automatic applyStimulus(input int h, input int v, input bit wv, input int wa, input int wd);
      int  t;
      bit  grant, wxfer, inRange, rd;
      h_count   = h[9:0];
      v_count   = v[9:0];
      wr_valid  = wv;
      wr_addr   = wa[19:0];
      wr_data   = wd[7:0];
      mem_rdata = 8'($urandom);
      if (h == 0) begin
         t          = (v == V_L) ? 0 : v + 1;
         mLineFetch = (t < HEIGHT) ? 1 : 0;
         mActive    = mLineFetch;
         mIssued    = 0;
         if (mLineFetch != 0) mBase = t * WIDTH;
         obsReads   = 0;
         obsGrants  = 0;
         obsFirstRead = -1;
      end
      grant   = (mActive == 0) || ((H_L - h) > (WIDTH - mIssued + GUARD));
      wxfer   = wv && grant;
      inRange = (wa < PIXELS);
      rd      = (mActive != 0) && (h != H_L) && !wxfer;
      #3;
      checkOutput("wr_ready", wr_ready, grant);
      checkOutput("mem_en", mem_en, (wxfer && inRange) || rd);
      checkOutput("mem_we", mem_we, wxfer && inRange);
      if (wxfer && inRange) begin
         checkOutput("mem_addr_wr", mem_addr, wa);
         checkOutput("mem_wdata", mem_wdata, wd & 8'hff);
      end else if (rd) begin
         checkOutput("mem_addr_rd", mem_addr, mBase + mIssued);
      end
      checkOutput("lb_we", lb_we, mPend);
      if (mPend != 0) begin
         checkOutput("lb_waddr", lb_waddr, mPendBank * 1024 + mPendCol);
         checkOutput("lb_wdata", lb_wdata, mem_rdata);
      end
      checkOutput("fetch_busy", fetch_busy, (mActive != 0) || (mPend != 0));
      checkOutput("lb_rd_bank", lb_rd_bank, mRdBank);
      checkOutput("underrun", underrun, mUnderrun);
      if (wr_ready) obsGrants++;
      if (mem_en && !mem_we) begin
         if (obsReads == 0) obsFirstRead = int'(mem_addr);
         obsReads++;
      end
      mPend     = rd;
      mPendCol  = mIssued;
      mPendBank = 1 - mRdBank;
      if (rd) begin
         mIssued++;
         if (mIssued == WIDTH) mActive = 0;
      end
      if (h == H_L) begin
         if (mActive != 0) begin
            mUnderrun = 1;
            mActive   = 0;
         end
         if (mLineFetch != 0) mRdBank = 1 - mRdBank;
      end
      @(posedge clk);
      #1;
   endtask

   // mode 0: writer idle; 1: wr_valid held high; 2: random requests, some out of range
   task automatic runSegment(input int v, input int mode, input int hFrom, input int hTo);
      bit wv;
      int wa;
      for (int h = hFrom; h <= hTo; h++) begin
         wv = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
         if (mode == 2 && $urandom_range(0, 9) == 0) wa = PIXELS + $urandom_range(0, 1000);
         else wa = $urandom_range(0, PIXELS - 1);
         applyStimulus(h, v, wv, wa, $urandom_range(0, 255));
      end
   endtask

   task automatic runLine(input int v, input int mode);
      runSegment(v, mode, 0, H_L);
   endtask

   initial begin
      rst_n = 1'b0;
      h_count = 10'd5; v_count = 10'd0; wr_valid = 1'b0;
      wr_addr = '0; wr_data = '0; mem_rdata = '0;
      modelReset();
      obsReads = 0; obsGrants = 0; obsFirstRead = -1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_mem_en", mem_en, 0);
      checkOutput("rst_mem_we", mem_we, 0);
      checkOutput("rst_lb_we", lb_we, 0);
      checkOutput("rst_fetch_busy", fetch_busy, 0);
      checkOutput("rst_lb_rd_bank", lb_rd_bank, 0);
      checkOutput("rst_underrun", underrun, 0);
      rst_n = 1'b1;

      // Released mid-line: stays idle, no fetch, no bank swap at end of line.
      runSegment(794, 2, 700, H_L);

      runLine(V_L, 0);
      checkOutput("wrap_reads", obsReads, WIDTH);
      checkOutput("wrap_first_addr", obsFirstRead, 0);
      for (int v = 0; v <= 4; v++) runLine(v, 2);

      runLine(5, 0);
      checkOutput("v5_reads", obsReads, WIDTH);
      checkOutput("v5_first_addr", obsFirstRead, 4098);

      runLine(6, 1);
      checkOutput("v6_grants", obsGrants, 209 + 5);
      checkOutput("v6_reads", obsReads, WIDTH);

      // Underrun: fetch starts, then the counter jumps to 800.
      runSegment(7, 0, 0, 0);
      runSegment(7, 0, 800, H_L);
      checkOutput("underrun_set", underrun, 1);
      runSegment(8, 0, 0, 99);

      // Asynchronous reset in the middle of a fetch.
      wr_valid = 1'b0;
      h_count  = 10'd100;
      rst_n    = 1'b0;
      #1;
      checkOutput("midrst_mem_en", mem_en, 0);
      checkOutput("midrst_mem_we", mem_we, 0);
      checkOutput("midrst_lb_we", lb_we, 0);
      checkOutput("midrst_fetch_busy", fetch_busy, 0);
      checkOutput("midrst_underrun", underrun, 0);
      checkOutput("midrst_lb_rd_bank", lb_rd_bank, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      modelReset();

      applyStimulus(101, 8, 1'b1, 524544, 8'h5A);
      runSegment(8, 2, 102, H_L);

      runLine(V_L, 2);
      runLine(0, 2);
      runLine(767, 1);
      checkOutput("blank_grants", obsGrants, H_L + 1);
      checkOutput("blank_reads", obsReads, 0);
      runLine(V_L, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_fb_fetch_arbiter.md
Name: vga_fb_fetch_arbiter

Overview:
- Sequences the single-port frame-buffer RAM on behalf of the VGA sync counter.
- During each display line it prefetches the next visible line into a ping-pong line buffer, so the pixel output always reads the bank holding the current line.
- It shares the same RAM port with a drawing client through a valid/ready write channel.
- Spare cycles go to the writer, but only while the line prefetch can still finish before end of line.

Parameters:
- WIDTH, 683, visible pixels per line
- HEIGHT, 768, visible lines per frame
- H_L, 896, last horizontal count value; a line lasts H_L+1 cycles
- V_L, 795, last vertical count value
- PW, 8, pixel word width
- AW, 20, frame-buffer address width (must be at least clog2(WIDTH*HEIGHT))
- GUARD, 4, slack cycles reserved for the fetch before the writer is refused

Ports:
- clk  in  1  system/pixel clock
- rst_n  in  1  asynchronous, active-low reset
- h_count  in  $clog2(H_L)  horizontal count from the sync counter
- v_count  in  $clog2(V_L)  vertical count from the sync counter
- wr_valid  in  1  writer request
- wr_ready  out  1  writer grant (combinational)
- wr_addr  in  AW  linear pixel address, row*WIDTH+col
- wr_data  in  PW  pixel value
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM address
- mem_wdata  out  PW  RAM write data
- mem_rdata  in  PW  RAM read data, valid 1 cycle after a read issue
- lb_we  out  1  line-buffer write strobe
- lb_waddr  out  1+clog2(WIDTH)  {bank, col}
- lb_wdata  out  PW  line-buffer data
- lb_rd_bank  out  1  bank the display reads for the current line
- fetch_busy  out  1  high while the current line's prefetch is incomplete
- underrun  out  1  sticky: a prefetch missed its deadline

Behaviour:
- Reset (async, rst_n=0):
  - FSM=IDLE; lb_rd_bank=0; underrun=0.
  - mem_en, mem_we, lb_we and fetch_busy all 0; base register 0; issued-word counter 0.
  - Holding reset mid-line aborts the fetch. After release the FSM waits in IDLE for the next h_count==0.
- FSM states: IDLE, FETCH, DONE.
  - At h_count==0 (any state), target t = (v_count==V_L) ? 0 : v_count+1.
  - If t<HEIGHT: go to FETCH, issued=0, write bank=~lb_rd_bank. Base becomes 0 if t==0, else base+WIDTH (no multiplier).
  - If t>=HEIGHT: go to DONE with no fetch.
  - FETCH→DONE in the cycle the read with col WIDTH-1 issues.
- Slack:
  - cycles_left = H_L - h_count; remaining = WIDTH - issued.
  - In FETCH, the writer may be granted only if cycles_left > remaining + GUARD.
  - In IDLE and DONE, the writer is granted unconditionally.
- Port use, one RAM op per cycle:
  - In FETCH, if wr_valid and slack allow: write granted, no read.
  - Otherwise a read issues: mem_en=1, mem_we=0, mem_addr=base+issued, then issued++.
  - wr_ready = grant condition and does not depend on wr_valid.
  - Write transfer occurs when wr_valid && wr_ready: mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data.
  - wr_addr >= WIDTH*HEIGHT: the request is accepted (handshake completes) and dropped, with mem_en=0.
- Read return: one cycle after each read issue, lb_we=1, lb_waddr={write bank, col}, lb_wdata=mem_rdata. Bank and col are pipeline-registered.
- fetch_busy = (state==FETCH) or a read return is pending.
- Bank swap:
  - At h_count==H_L, lb_rd_bank toggles if the line had a fetch; otherwise it holds.
  - If FETCH is still active at h_count==H_L: underrun<=1 (cleared only by reset), abort to DONE, still toggle.
  - A read return landing at h_count==H_L still writes its original bank.
- Widths: base and address arithmetic are AW bits with no wrap; issued is clog2(WIDTH)+1 bits.

Test Plan:
- No writer; v_count=5, h_count sweeping 0..896:
  - reads at h 0..682, addresses 4098..4780 (6*683 onward); lb_we at h 1..683 into bank 1;
  - fetch_busy falls after h 683; lb_rd_bank 0→1 at h 896.
- Writer wr_valid held 1, v_count=5:
  - wr_ready=1 for h 0..208 (209 writes), reads at h 209..891, wr_ready=1 again h 892..896;
  - no underrun, lb_rd_bank toggles.
- Frame wrap, v_count=795:
  - target line 0, base resets to 0, reads at addresses 0..682.
- Blanking line, v_count=767:
  - no reads; wr_ready=1 for all 897 cycles; lb_rd_bank does not toggle at h 896.
- Out-of-range write, wr_addr=524544 in IDLE:
  - wr_ready=1, handshake completes, mem_en=0.
- Underrun: fetch starts at h 0, then h_count jumps to 800 with writer idle:
  - at h 896 underrun=1, FSM in DONE, bank toggles; underrun holds until rst_n pulses low.
  - Separately, asserting rst_n=0 mid-FETCH: all outputs 0 immediately, and no fetch until the next h_count==0.
